// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the 100 Hz stopwatch: FSM states, BCD digit type,
// digit limits and the bit layout of the MM:SS.cc display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_ONES = 4'd9;
  localparam bcd_t BCD_MAX_TENS = 4'd5;

  localparam int NUM_DIGITS = 6;
  localparam int OFS_CS_O   = 0;
  localparam int OFS_CS_T   = 4;
  localparam int OFS_SEC_O  = 8;
  localparam int OFS_SEC_T  = 12;
  localparam int OFS_MIN_O  = 16;
  localparam int OFS_MIN_T  = 20;

  // Digit 3 (seconds tens) is the only one that stops at 5.
  function automatic bcd_t digit_max(input int idx);
    return (idx == 3) ? BCD_MAX_TENS : BCD_MAX_ONES;
  endfunction

  function automatic logic [23:0] limit_time(input int unsigned min_limit);
    logic [23:0] t;
    t = '0;
    t[OFS_MIN_T +: 4] = 4'(min_limit / 10);
    t[OFS_MIN_O +: 4] = 4'(min_limit % 10);
    t[OFS_SEC_T +: 4] = BCD_MAX_TENS;
    t[OFS_SEC_O +: 4] = BCD_MAX_ONES;
    t[OFS_CS_T  +: 4] = BCD_MAX_ONES;
    t[OFS_CS_O  +: 4] = BCD_MAX_ONES;
    return t;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch: counts 0..MAX on inc, clears on clr (clr wins),
// and raises a combinational carry when an increment rolls the digit over.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX_ONES
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t digit_o,
  output bcd_t digit_nxt_o,
  output logic carry_o
);

  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (inc_i) begin
      digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o     = digit_q;
  assign digit_nxt_o = digit_d;
  assign carry_o     = inc_i & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_100hz.sv
// MM:SS.cc stopwatch clocked by clk_50MHz; clk_100Hz is sampled as data to make a
// 10 ms tick. Start/stop, lap-hold and clear buttons drive a three-state FSM.
module stopwatch_100hz
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_LIMIT   = 59
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        clk_100Hz,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic        tick_10ms,
  output sw_state_t   dbg_state_o
);

  localparam logic [23:0] LIMIT_TIME = limit_time(MIN_LIMIT);

  // Reset value 1 keeps tick_10ms low during reset even if clk_100Hz is high.
  logic clk_100hz_q;
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      clk_100hz_q <= 1'b1;
    end else begin
      clk_100hz_q <= clk_100Hz;
    end
  end
  assign tick_10ms = clk_100Hz & ~clk_100hz_q;

  // Bit 0 start, bit 1 lap, bit 2 clear.
  logic [2:0] btn_sync_q [SYNC_STAGES];
  logic [2:0] btn_prev_q;
  logic [2:0] press_q;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= '0;
      end
      btn_prev_q <= '0;
      press_q    <= '0;
    end else begin
      btn_sync_q[0] <= {btn_clear, btn_lap, btn_start};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= btn_sync_q[i-1];
      end
      btn_prev_q <= btn_sync_q[SYNC_STAGES-1];
      press_q    <= btn_sync_q[SYNC_STAGES-1] & ~btn_prev_q;
    end
  end

  logic start_p, lap_p, clear_p;
  assign start_p = press_q[0];
  assign lap_p   = press_q[1];
  assign clear_p = press_q[2];

  sw_state_t   state_q;
  logic        running_q, lap_active_q, overflow_q;
  logic [23:0] lap_reg_q;

  logic                       cnt_en, wrap, zero_req, clr_all;
  logic [NUM_DIGITS-1:0][3:0] live, live_nxt;

  assign cnt_en   = (state_q == S_RUN) & tick_10ms;
  assign zero_req = clear_p & (state_q != S_RUN);
  assign clr_all  = zero_req | wrap;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    logic inc, carry;
    if (g == 0) begin : gen_lsd
      assign inc = cnt_en;
    end else begin : gen_chain
      assign inc = gen_digit[g-1].carry;
    end
    bcd_digit_counter #(
      .MAX(digit_max(g))
    ) u_digit (
      .clk_50MHz  (clk_50MHz),
      .rst        (rst),
      .inc_i      (inc),
      .clr_i      (clr_all),
      .digit_o    (live[g]),
      .digit_nxt_o(live_nxt[g]),
      .carry_o    (carry)
    );
  end

  // Top-digit carry only occurs at 99:59.99, which is the limit when MIN_LIMIT is 99.
  assign wrap = cnt_en & ((live == LIMIT_TIME) | gen_digit[NUM_DIGITS-1].carry);

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      lap_reg_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_p) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (start_p) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (clear_p) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end else if (start_p) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase

      if (zero_req) begin
        lap_active_q <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        if (wrap) begin
          overflow_q <= 1'b1;
        end
        // Capture takes the post-increment value so a same-cycle tick is included.
        if (lap_p) begin
          if (state_q == S_RUN && !lap_active_q) begin
            lap_active_q <= 1'b1;
            lap_reg_q    <= live_nxt;
          end else begin
            lap_active_q <= 1'b0;
          end
        end
      end
    end
  end

  assign disp_bcd    = lap_active_q ? lap_reg_q : live;
  assign running     = running_q;
  assign lap_active  = lap_active_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stopwatch_100hz.sv
// Bench for stopwatch_100hz: directed scenarios plus random tick/button sequences
// checked against a centisecond-count reference model.
module tb_stopwatch_100hz;
  import stopwatch_pkg::*;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned MINL    = 1;
  localparam int          WRAP_CS = (MINL + 1) * 6000;

  logic        clk_50MHz = 1'b0;
  logic        rst       = 1'b1;
  logic        clk_100Hz = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_lap   = 1'b0;
  logic        btn_clear = 1'b0;
  logic [23:0] disp_bcd;
  logic        running, lap_active, overflow, tick_10ms;
  sw_state_t   dbg_state;

  stopwatch_100hz #(
    .SYNC_STAGES(SYNC),
    .MIN_LIMIT  (MINL)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .clk_100Hz  (clk_100Hz),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .btn_clear  (btn_clear),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .tick_10ms  (tick_10ms),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #10 clk_50MHz = ~clk_50MHz;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [26:0] exp_q[$];
  int ticks_driven = 0;
  int ticks_seen   = 0;
  int tick_stuck   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} m_state_e;
  m_state_e m_state;
  int       m_time;
  int       m_lap_time;
  bit       m_lap;
  bit       m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic m_reset();
    m_state = M_IDLE;
    m_time = 0;
    m_lap_time = 0;
    m_lap = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic m_tick();
    if (m_state == M_RUN) begin
      m_time++;
      if (m_time == WRAP_CS) begin
        m_time = 0;
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic m_press(input bit s, input bit l, input bit c);
    m_state_e old;
    bit zero;
    old = m_state;
    zero = c && (old != M_RUN);
    case (old)
      M_IDLE:  if (s) m_state = M_RUN;
      M_RUN:   if (s) m_state = M_PAUSE;
      default: if (c) m_state = M_IDLE; else if (s) m_state = M_RUN;
    endcase
    if (zero) begin
      m_time = 0;
      m_lap = 1'b0;
      m_ovf = 1'b0;
    end else if (l) begin
      if (old == M_RUN && !m_lap) begin
        m_lap = 1'b1;
        m_lap_time = m_time;
      end else begin
        m_lap = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [26:0] exp;
    sw_state_t es;
    exp_q.push_back({m_ovf, m_lap, (m_state == M_RUN), to_bcd(m_lap ? m_lap_time : m_time)});
    exp = exp_q.pop_front();
    es = (m_state == M_RUN) ? S_RUN : (m_state == M_PAUSE) ? S_PAUSE : S_IDLE;
    check({tag, ".disp"},  32'(disp_bcd),   32'(exp[23:0]));
    check({tag, ".run"},   32'(running),    32'(exp[24]));
    check({tag, ".lap"},   32'(lap_active), 32'(exp[25]));
    check({tag, ".ovf"},   32'(overflow),   32'(exp[26]));
    check({tag, ".state"}, 32'(dbg_state),  32'(es));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50MHz);
      clk_100Hz = 1'b1;
      ticks_driven++;
      #1 if (tick_10ms) ticks_seen++;
      @(negedge clk_50MHz);
      if (tick_10ms) tick_stuck++;
      clk_100Hz = 1'b0;
      m_tick();
    end
  endtask

  // Optional tick lands in the same cycle as the press pulse reaching the FSM.
  task automatic drive_press(input bit s, input bit l, input bit c, input bit with_tick);
    @(negedge clk_50MHz);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    repeat (SYNC + 1) @(negedge clk_50MHz);
    if (with_tick) begin
      clk_100Hz = 1'b1;
      ticks_driven++;
      #1 if (tick_10ms) ticks_seen++;
    end
    @(negedge clk_50MHz);
    clk_100Hz = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    repeat (SYNC + 3) @(negedge clk_50MHz);
    if (with_tick) m_tick();
    m_press(s, l, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    repeat (3) @(negedge clk_50MHz);
    rst = 1'b0;
    @(negedge clk_50MHz);
    check("reset.disp", 32'(disp_bcd), 32'h0);
    check_model("reset");

    // Start and run 1.50 s.
    drive_press(1, 0, 0, 0);
    drive_ticks(150);
    check("run150.disp", 32'(disp_bcd), 32'h000150);
    check("run150.run", 32'(running), 32'h1);
    check_model("run150");

    // Asynchronous reset while running.
    drive_ticks(7);
    @(negedge clk_50MHz);
    rst = 1'b1;
    #1;
    check("rst_async.disp", 32'(disp_bcd), 32'h0);
    check("rst_async.run", 32'(running), 32'h0);
    repeat (2) @(negedge clk_50MHz);
    rst = 1'b0;
    m_reset();
    @(negedge clk_50MHz);
    check("rst_mid.state", 32'(dbg_state), 32'(S_IDLE));
    check_model("rst_mid");

    // Pause holds the time, clear returns to IDLE.
    drive_press(1, 0, 0, 0);
    drive_ticks(150);
    drive_press(1, 0, 0, 0);
    drive_ticks(10);
    check("pause.disp", 32'(disp_bcd), 32'h000150);
    check("pause.run", 32'(running), 32'h0);
    check_model("pause");
    drive_press(0, 0, 1, 0);
    check("clear.disp", 32'(disp_bcd), 32'h0);
    check_model("clear");

    // Lap hold and release.
    drive_press(1, 0, 0, 0);
    drive_ticks(25);
    drive_press(0, 1, 0, 0);
    drive_ticks(30);
    check("lap_hold.disp", 32'(disp_bcd), 32'h000025);
    check("lap_hold.lap", 32'(lap_active), 32'h1);
    check_model("lap_hold");
    drive_press(0, 1, 0, 0);
    check("lap_rel.disp", 32'(disp_bcd), 32'h000055);
    check_model("lap_rel");

    // Clear ignored in RUN; start+clear: RUN->PAUSE, PAUSE->IDLE.
    drive_press(0, 0, 1, 0);
    check("clr_in_run.disp", 32'(disp_bcd), 32'h000055);
    check("clr_in_run.run", 32'(running), 32'h1);
    drive_press(1, 0, 1, 0);
    check("sc_run.state", 32'(dbg_state), 32'(S_PAUSE));
    check_model("sc_run");
    drive_press(1, 0, 1, 0);
    check("sc_pause.state", 32'(dbg_state), 32'(S_IDLE));
    check("sc_pause.disp", 32'(disp_bcd), 32'h0);
    check_model("sc_pause");

    // Tick coincident with start, and with lap capture.
    drive_press(1, 0, 0, 0);
    drive_ticks(5);
    drive_press(1, 0, 0, 1);
    check("tick_start_run.disp", 32'(disp_bcd), 32'h000006);
    check_model("tick_start_run");
    drive_press(1, 0, 0, 1);
    check("tick_start_pause.disp", 32'(disp_bcd), 32'h000006);
    check_model("tick_start_pause");
    drive_press(0, 1, 0, 1);
    drive_ticks(3);
    check("tick_lap.disp", 32'(disp_bcd), 32'h000007);
    drive_press(0, 1, 0, 0);
    check_model("tick_lap");
    drive_press(1, 0, 0, 0);
    drive_press(0, 0, 1, 0);

    // Wrap past MINL:59.99.
    drive_press(1, 0, 0, 0);
    drive_ticks(WRAP_CS - 1);
    check("limit.disp", 32'(disp_bcd), 32'h015999);
    check("limit.ovf", 32'(overflow), 32'h0);
    drive_ticks(1);
    check("wrap.disp", 32'(disp_bcd), 32'h0);
    check("wrap.ovf", 32'(overflow), 32'h1);
    check("wrap.run", 32'(running), 32'h1);
    check_model("wrap");
    drive_ticks(1);
    drive_press(1, 0, 0, 0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    drive_press(0, 0, 1, 0);
    check("ovf_clear", 32'(overflow), 32'h0);
    check_model("ovf_clear");

    // Random tick / button sequences.
    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        drive_ticks(int'($urandom_range(1, 250)));
      end else begin
        drive_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), op == 3);
      end
      check_model($sformatf("rnd%0d", k));
    end

    check("tick.count", 32'(ticks_seen), 32'(ticks_driven));
    check("tick.width", 32'(tick_stuck), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
